// File: rtl/stream_edge_filter_pkg.sv
// Shared encodings for the streaming median/Sobel edge filter.
package edge_filter_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_MEDIAN = 2'd1,
    MODE_SOBEL  = 2'd2,
    MODE_BOTH   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_e;

  localparam int unsigned MAG_EXTRA = 4;

  function automatic int unsigned mag_width(input int unsigned data_w);
    return data_w + MAG_EXTRA;
  endfunction

endpackage

// File: rtl/stream_edge_filter_window.sv
// 3x3 sliding window over a raster stream: two line buffers, window registers,
// and the row/column position of the window centre with its border flag.
module window_3x3
  import edge_filter_pkg::*;
#(
  parameter int unsigned WIDTH  = 512,
  parameter int unsigned HEIGHT = 512,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LAG    = WIDTH + 2
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic [DATA_W-1:0]       din_i,
  output logic [8:0][DATA_W-1:0]  win_o,
  output logic                    border_o
);

  localparam int unsigned CNT_W = $clog2(LAG + 2);
  localparam int unsigned COL_W = $clog2(WIDTH);
  localparam int unsigned ROW_W = $clog2(HEIGHT);

  logic [DATA_W-1:0] lb_a [WIDTH];
  logic [DATA_W-1:0] lb_b [WIDTH];
  logic [DATA_W-1:0] lb_a_rd, lb_b_rd;

  logic [8:0][DATA_W-1:0] win_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_cur;
  logic [COL_W-1:0] ptr_q, ptr_d, col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  assign lb_a_rd  = lb_a[ptr_q];
  assign lb_b_rd  = lb_b[ptr_q];
  assign win_o    = win_q;
  assign border_o = (row_q == '0) || (row_q == ROW_W'(HEIGHT - 1)) ||
                    (col_q == '0) || (col_q == COL_W'(WIDTH - 1));

  // LAG counts the ingests before the centre reaches pixel (0,0) of this stream.
  always_comb begin
    cnt_cur = clr_i ? '0 : cnt_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    row_d   = row_q;
    col_d   = col_q;
    if (en_i) begin
      ptr_d = (ptr_q == COL_W'(WIDTH - 1)) ? '0 : ptr_q + 1'b1;
      cnt_d = (cnt_cur <= CNT_W'(LAG)) ? cnt_cur + 1'b1 : cnt_cur;
      if (cnt_cur == CNT_W'(LAG)) begin
        row_d = '0;
        col_d = '0;
      end else if (cnt_cur > CNT_W'(LAG)) begin
        if (col_q == COL_W'(WIDTH - 1)) begin
          col_d = '0;
          row_d = (row_q == ROW_W'(HEIGHT - 1)) ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (en_i) begin
      lb_a[ptr_q] <= din_i;
      lb_b[ptr_q] <= lb_a_rd;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      win_q <= '0;
      cnt_q <= '0;
      ptr_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      row_q <= row_d;
      col_q <= col_d;
      if (en_i) begin
        for (int unsigned r = 0; r < 3; r++) begin
          win_q[r*3]   <= win_q[r*3+1];
          win_q[r*3+1] <= win_q[r*3+2];
        end
        win_q[2] <= lb_b_rd;
        win_q[5] <= lb_a_rd;
        win_q[8] <= din_i;
      end
    end
  end

endmodule

// File: rtl/stream_edge_filter.sv
// Streaming edge filter: input register, median window stage, Sobel window stage,
// output register. The whole pipeline moves one position per step.
module stream_edge_filter
  import edge_filter_pkg::*;
#(
  parameter int unsigned WIDTH  = 512,
  parameter int unsigned HEIGHT = 512,
  parameter int unsigned DATA_W = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [1:0]                    mode,
  input  logic [DATA_W+MAG_EXTRA-1:0]   threshold,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_pixel,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_pixel,
  output logic                          out_last,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int unsigned MAG_W    = mag_width(DATA_W);
  localparam int unsigned NPIX     = WIDTH * HEIGHT;
  localparam int unsigned VALID_AT = 2 * WIDTH + 6;
  localparam int unsigned TOTAL    = NPIX + VALID_AT;
  localparam int unsigned STEP_W   = $clog2(TOTAL + 1);
  localparam int unsigned NET_A [19] = '{1,4,7,0,3,6,1,4,7,0,5,4,3,1,2,4,4,6,4};
  localparam int unsigned NET_B [19] = '{2,5,8,1,4,7,2,5,8,3,8,7,6,4,5,7,2,4,2};

  state_e state_q, state_d;
  mode_e  mode_q;
  logic [MAG_W-1:0]  thr_q;
  logic [STEP_W-1:0] step_q, step_d;
  logic [DATA_W-1:0] in_q, k1_q, k1_d, k2_d, out_pixel_q;
  logic out_valid_q, out_last_q, frame_done_q, frame_done_d;
  logic accept, step, first_step, med_en, sob_en, last_taken;

  logic [8:0][DATA_W-1:0] win1, win2;
  logic border1, border2;
  logic signed [MAG_W-1:0] gx, gy;
  logic [MAG_W-1:0] mag;

  assign in_ready   = !reset && (state_q != ST_FLUSH) && out_ready;
  assign accept     = in_valid && in_ready;
  assign step       = accept || ((state_q == ST_FLUSH) && (step_q < STEP_W'(TOTAL)) &&
                                 (out_ready || !out_valid_q));
  assign first_step = step && (state_q == ST_IDLE);
  assign last_taken = out_valid_q && out_last_q && out_ready;
  assign med_en     = (mode_q == MODE_MEDIAN) || (mode_q == MODE_BOTH);
  assign sob_en     = (mode_q == MODE_SOBEL) || (mode_q == MODE_BOTH);

  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign out_last   = out_last_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;

  window_3x3 #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .DATA_W(DATA_W), .LAG(WIDTH + 2)) u_win_median (
    .clock_i(clock), .reset_i(reset), .en_i(step), .clr_i(first_step),
    .din_i(in_q), .win_o(win1), .border_o(border1)
  );

  window_3x3 #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .DATA_W(DATA_W), .LAG(2 * WIDTH + 5)) u_win_sobel (
    .clock_i(clock), .reset_i(reset), .en_i(step), .clr_i(first_step),
    .din_i(k1_q), .win_o(win2), .border_o(border2)
  );

  function automatic logic [DATA_W-1:0] median9(input logic [8:0][DATA_W-1:0] w);
    logic [DATA_W-1:0] s [9];
    logic [DATA_W-1:0] t;
    for (int unsigned i = 0; i < 9; i++) s[i] = w[i];
    for (int unsigned i = 0; i < 19; i++) begin
      if (s[NET_A[i]] > s[NET_B[i]]) begin
        t           = s[NET_A[i]];
        s[NET_A[i]] = s[NET_B[i]];
        s[NET_B[i]] = t;
      end
    end
    return s[4];
  endfunction

  function automatic logic signed [MAG_W-1:0] px(input logic [DATA_W-1:0] p);
    return $signed({{(MAG_W - DATA_W){1'b0}}, p});
  endfunction

  always_comb begin
    k1_d = (med_en && !border1) ? median9(win1) : win1[4];
    gx   = (px(win2[2]) + (px(win2[5]) <<< 1) + px(win2[8])) -
           (px(win2[0]) + (px(win2[3]) <<< 1) + px(win2[6]));
    gy   = (px(win2[6]) + (px(win2[7]) <<< 1) + px(win2[8])) -
           (px(win2[0]) + (px(win2[1]) <<< 1) + px(win2[2]));
    mag  = (gx[MAG_W-1] ? $unsigned(-gx) : $unsigned(gx)) +
           (gy[MAG_W-1] ? $unsigned(-gy) : $unsigned(gy));
    if (!sob_en)             k2_d = win2[4];
    else if (border2)        k2_d = '0;
    else if (mag > thr_q)    k2_d = '1;
    else                     k2_d = '0;
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step ? step_q + 1'b1 : step_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_RUN;
      ST_RUN:   if (accept && (step_q == STEP_W'(NPIX - 1))) state_d = ST_FLUSH;
      ST_FLUSH: if (last_taken) begin
        state_d      = ST_IDLE;
        step_d       = '0;
        frame_done_d = 1'b1;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      step_q       <= '0;
      mode_q       <= MODE_BYPASS;
      thr_q        <= '0;
      in_q         <= '0;
      k1_q         <= '0;
      out_pixel_q  <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      frame_done_q <= frame_done_d;
      if (first_step) begin
        mode_q <= mode_e'(mode);
        thr_q  <= threshold;
      end
      // Output beat for step t is pixel t-VALID_AT; steps before that fill the pipe.
      if (step) begin
        in_q        <= in_pixel;
        k1_q        <= k1_d;
        out_pixel_q <= k2_d;
        out_valid_q <= (step_q >= STEP_W'(VALID_AT));
        out_last_q  <= (step_q == STEP_W'(TOTAL - 1));
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_edge_filter.sv
// Randomised self-checking bench for stream_edge_filter (8x8 frames).
module tb_stream_edge_filter;
  localparam int W = 8;
  localparam int H = 8;
  localparam int N = W * H;

  logic clock = 1'b0;
  logic reset;
  logic [1:0] mode;
  logic [11:0] threshold;
  logic in_valid, in_ready, out_valid, out_ready, out_last, busy, frame_done;
  logic [7:0] in_pixel, out_pixel;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] img [N];
  logic [7:0] outp [N];
  logic [7:0] exp_px [N];
  int nout, last_pos, last_cnt, fd_cnt, stall_bad;
  bit timed_out;

  always #5 clock = ~clock;

  stream_edge_filter #(.WIDTH(W), .HEIGHT(H), .DATA_W(8)) dut (
    .clock(clock), .reset(reset), .mode(mode), .threshold(threshold),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_last(out_last), .busy(busy), .frame_done(frame_done)
  );

  // Reference: whole-frame arithmetic straight from the filter definitions.
  function automatic bit is_border(int r, int c);
    return (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
  endfunction

  function automatic void compute_expected(input logic [1:0] m, input int th);
    int a [N];
    int v [9];
    int t, gx, gy, mag, k;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (m[0] && !is_border(r, c)) begin
          k = 0;
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin v[k] = img[(r+dr)*W + c + dc]; k++; end
          for (int i = 1; i < 9; i++)
            for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin t = v[j]; v[j] = v[j-1]; v[j-1] = t; end
          a[r*W+c] = v[4];
        end else a[r*W+c] = img[r*W+c];
      end
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (!m[1]) exp_px[r*W+c] = 8'(a[r*W+c]);
        else if (is_border(r, c)) exp_px[r*W+c] = 8'd0;
        else begin
          gx = (a[(r-1)*W+c+1] + 2*a[r*W+c+1] + a[(r+1)*W+c+1])
             - (a[(r-1)*W+c-1] + 2*a[r*W+c-1] + a[(r+1)*W+c-1]);
          gy = (a[(r+1)*W+c-1] + 2*a[(r+1)*W+c] + a[(r+1)*W+c+1])
             - (a[(r-1)*W+c-1] + 2*a[(r-1)*W+c] + a[(r-1)*W+c+1]);
          mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
          exp_px[r*W+c] = (mag > th) ? 8'd255 : 8'd0;
        end
      end
  endfunction

  // Drives one frame from img[] and records what leaves the DUT.
  task automatic run_frame(input logic [1:0] m, input int th, input bit bp,
                           input int sw_at, input logic [1:0] sw_mode);
    int nin = 0, post = 0, idx;
    bit prev_stall = 0;
    logic [7:0] prev_pix = '0;
    nout = 0; last_pos = -1; last_cnt = 0; fd_cnt = 0; stall_bad = 0;
    mode = m; threshold = 12'(th);
    for (int cyc = 0; cyc < 3000 && !(nout >= N && post >= 3); cyc++) begin
      @(negedge clock);
      out_ready = bp ? ((cyc % 2) == 1) : 1'b1;
      in_valid  = (nin < N) && (bp ? ($urandom_range(0, 1) == 1) : 1'b1);
      idx       = (nin < N) ? nin : N - 1;
      in_pixel  = img[idx];
      #1;
      if (prev_stall && (out_valid !== 1'b1 || out_pixel !== prev_pix)) stall_bad++;
      if (frame_done === 1'b1) fd_cnt++;
      if (in_valid && in_ready) begin
        nin++;
        if (nin == sw_at) mode = sw_mode;
      end
      if (out_valid && out_ready) begin
        if (nout < N) outp[nout] = out_pixel;
        if (out_last) begin last_cnt++; last_pos = nout; end
        nout++;
      end
      prev_stall = out_valid && !out_ready;
      prev_pix   = out_pixel;
      if (nout >= N) post++;
    end
    timed_out = (nout < N);
    @(negedge clock);
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    #12;
    vectors++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset in_ready got %b want 0", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    vectors++; if (out_last !== 1'b0)  begin errors++; $display("FAIL reset out_last got %b want 0", out_last); end
    vectors++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset busy got %b want 0", busy); end
    vectors++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done got %b want 0", frame_done); end
    vectors++; if (out_pixel !== 8'd0) begin errors++; $display("FAIL reset out_pixel got %0d want 0", out_pixel); end
    @(negedge clock); reset = 1'b0; #1;
    vectors++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL idle in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_bypass;
    for (int i = 0; i < N; i++) img[i] = 8'(i);
    run_frame(2'd0, 0, 1'b0, -1, 2'd0);
    vectors++; if (timed_out) begin errors++; $display("FAIL bypass beats got %0d want %0d", nout, N); end
    for (int i = 0; i < N; i++) begin
      vectors++; if (outp[i] !== 8'(i)) begin errors++; $display("FAIL bypass px[%0d] got %0d want %0d", i, outp[i], i); end
    end
    vectors++; if (last_pos != N - 1 || last_cnt != 1) begin errors++; $display("FAIL bypass out_last at %0d (x%0d) want %0d (x1)", last_pos, last_cnt, N - 1); end
    vectors++; if (fd_cnt != 1) begin errors++; $display("FAIL bypass frame_done pulses got %0d want 1", fd_cnt); end
    vectors++; if (nout != N) begin errors++; $display("FAIL bypass total beats got %0d want %0d", nout, N); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL bypass busy after frame got %b want 0", busy); end
  endtask

  task automatic test_median;
    for (int i = 0; i < N; i++) img[i] = 8'd0;
    img[3*W+3] = 8'd255;
    run_frame(2'd1, 0, 1'b0, -1, 2'd0);
    vectors++; if (timed_out) begin errors++; $display("FAIL median beats got %0d want %0d", nout, N); end
    for (int i = 0; i < N; i++) begin
      vectors++; if (outp[i] !== 8'd0) begin errors++; $display("FAIL median px[%0d] got %0d want 0", i, outp[i]); end
    end
  endtask

  task automatic step_image;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r*W+c] = (c >= 4) ? 8'd200 : 8'd0;
  endtask

  task automatic test_sobel;
    logic [7:0] want;
    step_image();
    run_frame(2'd2, 150, 1'b0, -1, 2'd0);
    vectors++; if (timed_out) begin errors++; $display("FAIL sobel beats got %0d want %0d", nout, N); end
    for (int i = 0; i < N; i++) begin
      want = (i / W >= 1 && i / W <= 6 && (i % W == 3 || i % W == 4)) ? 8'd255 : 8'd0;
      vectors++; if (outp[i] !== want) begin errors++; $display("FAIL sobel px[%0d] got %0d want %0d", i, outp[i], want); end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] want;
    step_image();
    run_frame(2'd2, 150, 1'b1, -1, 2'd0);
    vectors++; if (timed_out) begin errors++; $display("FAIL bp beats got %0d want %0d", nout, N); end
    vectors++; if (stall_bad != 0) begin errors++; $display("FAIL bp stall_stability violations got %0d want 0", stall_bad); end
    vectors++; if (last_pos != N - 1) begin errors++; $display("FAIL bp out_last at %0d want %0d", last_pos, N - 1); end
    for (int i = 0; i < N; i++) begin
      want = (i / W >= 1 && i / W <= 6 && (i % W == 3 || i % W == 4)) ? 8'd255 : 8'd0;
      vectors++; if (outp[i] !== want) begin errors++; $display("FAIL bp px[%0d] got %0d want %0d", i, outp[i], want); end
    end
  endtask

  task automatic test_reset_midframe;
    int acc = 0;
    mode = 2'd3; threshold = 12'd10;
    for (int cyc = 0; cyc < 200 && acc < 20; cyc++) begin
      @(negedge clock);
      in_valid = 1'b1; in_pixel = 8'($urandom); out_ready = 1'b1;
      #1; if (in_ready) acc++;
    end
    @(negedge clock); in_valid = 1'b0; reset = 1'b1; #1;
    vectors++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0)
      begin errors++; $display("FAIL midreset outputs valid/busy/ready got %b%b%b want 000", out_valid, busy, in_ready); end
    @(negedge clock); reset = 1'b0;
    for (int i = 0; i < N; i++) img[i] = 8'(i);
    run_frame(2'd0, 0, 1'b0, -1, 2'd0);
    vectors++; if (timed_out || nout != N) begin errors++; $display("FAIL midreset beats got %0d want %0d", nout, N); end
    for (int i = 0; i < N; i++) begin
      vectors++; if (outp[i] !== 8'(i)) begin errors++; $display("FAIL midreset px[%0d] got %0d want %0d", i, outp[i], i); end
    end
  endtask

  task automatic test_mode_change;
    for (int i = 0; i < N; i++) img[i] = 8'($urandom);
    run_frame(2'd0, 40, 1'b0, 10, 2'd3);
    vectors++; if (timed_out) begin errors++; $display("FAIL modechg beats got %0d want %0d", nout, N); end
    for (int i = 0; i < N; i++) begin
      vectors++; if (outp[i] !== img[i]) begin errors++; $display("FAIL modechg px[%0d] got %0d want %0d", i, outp[i], img[i]); end
    end
    for (int i = 0; i < N; i++) img[i] = 8'($urandom);
    compute_expected(2'd3, 40);
    run_frame(2'd3, 40, 1'b0, -1, 2'd0);
    vectors++; if (timed_out) begin errors++; $display("FAIL nextmode beats got %0d want %0d", nout, N); end
    for (int i = 0; i < N; i++) begin
      vectors++; if (outp[i] !== exp_px[i]) begin errors++; $display("FAIL nextmode px[%0d] got %0d want %0d", i, outp[i], exp_px[i]); end
    end
  endtask

  task automatic test_random;
    logic [1:0] m;
    int th;
    bit bp;
    for (int f = 0; f < 4; f++) begin
      m = 2'($urandom_range(0, 3));
      th = $urandom_range(0, 1200);
      bp = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < N; i++) img[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(90, 110));
      compute_expected(m, th);
      run_frame(m, th, bp, -1, 2'd0);
      vectors++; if (timed_out || stall_bad != 0 || fd_cnt != 1)
        begin errors++; $display("FAIL random[%0d] beats/stall/done got %0d/%0d/%0d want %0d/0/1", f, nout, stall_bad, fd_cnt, N); end
      for (int i = 0; i < N; i++) begin
        vectors++; if (outp[i] !== exp_px[i])
          begin errors++; $display("FAIL random[%0d] mode %0d px[%0d] got %0d want %0d", f, m, i, outp[i], exp_px[i]); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; mode = 2'd0; threshold = '0;
    in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1;
    test_reset();
    test_bypass();
    test_median();
    test_sobel();
    test_backpressure();
    test_reset_midframe();
    test_mode_change();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/stream_edge_filter.md
# stream_edge_filter

Streaming, parametrised successor to the frame-buffered median/Sobel edge detector. Accepts a raster-order pixel stream over a valid/ready handshake, optionally applies a 3×3 median filter, then optionally a 3×3 Sobel magnitude threshold. Only two line buffers per window stage are used; no full-frame memory is held. It sits between the pixel source (file reader or serial link) and the output sink in the edge-detection pipeline.

## Interface

**Parameters**
- `WIDTH`, 512: pixels per row (≥ 4).
- `HEIGHT`, 512: rows per frame (≥ 4).
- `DATA_W`, 8: bits per pixel.

**Ports**
- `clock` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `mode` input 2: 0 = bypass, 1 = median only, 2 = Sobel only, 3 = median then Sobel. Sampled at frame start.
- `threshold` input DATA_W+4: edge threshold. Sampled at frame start.
- `in_valid` input 1: `in_pixel` is valid.
- `in_ready` output 1: block accepts a beat when `in_valid && in_ready`.
- `in_pixel` input DATA_W: input pixel.
- `out_valid` output 1: `out_pixel` is valid.
- `out_ready` input 1: sink accepts a beat when `out_valid && out_ready`.
- `out_pixel` output DATA_W: output pixel.
- `out_last` output 1: high on the final (WIDTH·HEIGHT-th) output beat.
- `busy` output 1: high from the first accepted beat until the last output beat is accepted.
- `frame_done` output 1: one-cycle pulse on the cycle after the last output beat is accepted.

## Operation

- **FSM states:**
  - IDLE: `in_ready` = `out_ready`.
  - RUN: `in_ready` = `out_ready`.
  - FLUSH: `in_ready` = 0.
- **Transitions:**
  - IDLE→RUN on the first accepted beat. `mode` and `threshold` are latched on that beat.
  - RUN→FLUSH after beat WIDTH·HEIGHT is accepted.
  - FLUSH→IDLE after `out_last` is accepted. `frame_done` pulses on this transition.
- **Window stage:**
  - Tracks row and column counters.
  - Holds two line buffers (depth WIDTH) and a 3×3 register window.
  - Output for centre (r,c) is formed once input (r+1,c+1) is available. At the right and bottom edges, no lookahead is needed because those are border pixels.
  - In FLUSH, the stage self-advances through the remaining WIDTH+1 positions using buffered data.
- **Median stage:**
  - Border pixels (r=0, r=HEIGHT-1, c=0, c=WIDTH-1) pass through unchanged.
  - Interior pixels output the 5th-smallest of the 9 window pixels (exact median).
- **Sobel stage:**
  - gx = (p[r-1][c+1] + 2p[r][c+1] + p[r+1][c+1]) − (p[r-1][c-1] + 2p[r][c-1] + p[r+1][c-1]).
  - gy = (p[r+1][c-1] + 2p[r+1][c] + p[r+1][c+1]) − (p[r-1][c-1] + 2p[r-1][c] + p[r-1][c+1]).
  - Both are signed, width DATA_W+4. mag = |gx| + |gy|, unsigned DATA_W+4, with no overflow possible.
  - Output is all-ones if mag > threshold, else 0. Border pixels output 0.
- **Bypass:** a stage that is not selected forwards its input with unchanged latency. Output timing is therefore mode-independent.
- **Beat count:** exactly WIDTH·HEIGHT outputs per frame, in raster order; no drops or duplicates.

## Timing

- **Reset values:**
  - `in_ready`, `out_valid`, `out_last`, `busy`, `frame_done` = 0.
  - `out_pixel` = 0.
  - FSM = IDLE; counters = 0.
- **Stall:** the whole pipeline advances only when `out_ready` is high or the output register is empty. `out_valid` and `out_pixel` hold stable while stalled.
- **Latency:**
  - One window stage: the output for (r,c) becomes valid 2 cycles after input (r+1,c+1) is accepted, with no stalls.
  - Full pipeline (two stages): output (r,c) becomes valid 4 cycles after input (r+2,c+2) is accepted, or at the matching FLUSH step.
- **Between frames:** back-to-back frames are not overlapped. The next frame's first beat is accepted only in IDLE.
- **Mid-frame changes:** changes to `mode` or `threshold` during a frame have no effect until the next frame.
- **Reset mid-frame:** all in-flight data is discarded and outputs return to reset values immediately. The next accepted beat is treated as pixel (0,0).
- **Simultaneous events:** an `out_last` accept and an `in_valid` beat on the same cycle must not accept the input. The input is accepted on the following IDLE cycle.

## Structure

- **Shared package `edge_filter_pkg`:**
  - Mode encodings (`MODE_BYPASS`, `MODE_MEDIAN`, `MODE_SOBEL`, `MODE_BOTH`).
  - FSM state encoding.
  - Magnitude-width constant (`DATA_W+4`).
- **Sub-module `window_3x3`:**
  - Contains the line buffers, the window, the row/column counters, and border flags.
  - Instantiated twice; the median and Sobel kernels consume its outputs.
- **Median kernel:** a 19-comparator sorting network, registered once.

## Test plan

All tests use WIDTH=8, HEIGHT=8, DATA_W=8.

1. **Bypass:** `mode`=0, input ramp 0..63 → output 0..63 in order; `out_last` on beat 64; `frame_done` pulses once.
2. **Median impulse removal:** `mode`=1, all-zero frame with 255 at (3,3) → all 64 outputs are 0.
3. **Sobel vertical step:** `mode`=2, `threshold`=150, columns 0–3 = 0 and 4–7 = 200 → rows 1–6, columns 3 and 4 = 255; all other pixels = 0.
4. **Backpressure:** case 3 with `out_ready` toggling every cycle and `in_valid` random → identical 64-beat output; `out_pixel` stable while stalled.
5. **Reset mid-frame:** assert `reset` after 20 input beats, then send a full case-1 frame → exact ramp output with no residue from the aborted frame.
6. **Mode change mid-frame:** start frame with `mode`=0, switch to 3 at beat 10 → the whole frame is bypassed; the next frame uses `mode`=3.
